// File: rtl/mem_copy_master_pkg.sv
// mem_copy_master: shared types and constants
// for the PicoRV32-bus copy engine.
package mem_copy_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FIN
  } state_e;

  localparam logic [3:0]  WSTRB_ALL  = 4'b1111;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_copy_master_watchdog.sv
// bus_watchdog: clear/enable wait counter that flags
// a request left unanswered for TIMEOUT cycles.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds earlier wait cycles; this one is the last
  assign expired = (TIMEOUT != 0) && en
                && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_copy_master.sv
// mem_copy_master: word-by-word read/write copy
// engine driving the PicoRV32 native memory bus.
module mem_copy_master
  import mem_copy_master_pkg::*;
#(
  parameter int unsigned LEN_W   = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] cnt_q;
  logic             abort_q;
  logic             hold_q;
  logic             wd_clr, wd_en, wd_exp;
  logic             in_xfer;

  assign in_xfer = (state_q == ST_RD)
                || (state_q == ST_WR);

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_exp)
  );

  always_comb begin
    state_d   = state_q;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    wd_clr    = !in_xfer || mem_ready;
    wd_en     = in_xfer && !mem_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (word_count != '0) ? ST_RD
                                       : ST_FIN;
        end
      end
      ST_RD: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        busy      = 1'b1;
        if (mem_ready) begin
          state_d = ST_WR;
        end else if (wd_exp) begin
          state_d = ST_FIN;
        end
      end
      ST_WR: begin
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_wstrb = WSTRB_ALL;
        busy      = 1'b1;
        if (mem_ready) begin
          state_d = (cnt_q == LEN_W'(1)) ? ST_FIN
                                         : ST_RD;
        end else if (wd_exp) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        // an empty copy spends one extra busy cycle here
        if (hold_q) begin
          busy = 1'b1;
        end else begin
          done    = 1'b1;
          error   = abort_q;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q   <= word_align(src_addr);
            dst_q   <= word_align(dst_addr);
            cnt_q   <= word_count;
            hold_q  <= (word_count == '0);
            abort_q <= 1'b0;
          end
        end
        ST_RD: begin
          if (mem_ready) begin
            data_q <= mem_rdata;
            src_q  <= src_q + WORD_BYTES;
          end else if (wd_exp) begin
            abort_q <= 1'b1;
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            dst_q <= dst_q + WORD_BYTES;
            cnt_q <= cnt_q - LEN_W'(1);
          end else if (wd_exp) begin
            abort_q <= 1'b1;
          end
        end
        ST_FIN: begin
          if (hold_q) begin
            hold_q <= 1'b0;
          end else begin
            abort_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: directed checks of the copy
// engine against behavioural memory responders.
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        w_start = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [8:0]  wc = '0;

  logic        busy, done, error;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;

  logic        w_busy, w_done, w_error;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic [31:0] w_addr, w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_rdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_copy_master dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src),
    .dst_addr   (dst),
    .word_count (wc),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata)
  );

  mem_copy_master #(
    .LEN_W   (9),
    .TIMEOUT (8)
  ) dut_wd (
    .clk        (clk),
    .reset      (reset),
    .start      (w_start),
    .src_addr   (src),
    .dst_addr   (dst),
    .word_count (wc),
    .busy       (w_busy),
    .done       (w_done),
    .error      (w_error),
    .mem_valid  (w_valid),
    .mem_ready  (w_ready),
    .mem_addr   (w_addr),
    .mem_wdata  (w_wdata),
    .mem_wstrb  (w_wstrb),
    .mem_rdata  (w_rdata)
  );

  // main RAM responder with programmable ack delay
  logic [31:0] mem [int unsigned];
  logic [31:0] rd_log[$];
  logic [31:0] wr_log[$];
  int          maxd  = 0;
  int          cur_d = 0;
  int          wcnt  = 0;

  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      wcnt  = 0;
      cur_d = 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_valid && !mem_ready) begin
        if (wcnt >= cur_d) begin
          mem_ready <= 1'b1;
          wcnt  = 0;
          cur_d = $urandom_range(maxd, 0);
          if (mem_wstrb == 4'hF) begin
            mem[mem_addr[31:2]] = mem_wdata;
            wr_log.push_back(mem_addr);
          end else begin
            mem_rdata <= mem.exists(mem_addr[31:2])
                       ? mem[mem_addr[31:2]]
                       : 32'hDEAD_BEEF;
            rd_log.push_back(mem_addr);
          end
        end else begin
          wcnt = wcnt + 1;
        end
      end
    end
  end

  // watchdog responder: never answers 0x3000_0000
  always @(posedge clk) begin
    if (reset) begin
      w_ready <= 1'b0;
    end else begin
      w_ready <= 1'b0;
      if (w_valid && !w_ready
          && w_addr != 32'h3000_0000) begin
        w_ready <= 1'b1;
        w_rdata <= 32'h5A5A_0000 | w_addr;
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // request fields must hold while waiting for ready
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic [67:0] p_req   = '0;

  always @(negedge clk) begin
    if (!reset && p_valid && !p_ready && mem_valid) begin
      total++;
      assert ({mem_addr, mem_wdata, mem_wstrb} === p_req)
      else begin
        bad++;
        $error("FAIL stable observed=%0h expected=%0h",
               {mem_addr, mem_wdata, mem_wstrb}, p_req);
      end
    end
    p_valid = mem_valid && !reset;
    p_ready = mem_ready;
    p_req   = {mem_addr, mem_wdata, mem_wstrb};
  end

  int k;
  bit err_at_done;
  bit busy_first;
  bit busy_last;
  bit saw_valid;

  task automatic run_copy(
    input logic [31:0] s,
    input logic [31:0] d,
    input logic [8:0]  n,
    input int          limit
  );
    @(negedge clk);
    src   = s;
    dst   = d;
    wc    = n;
    start = 1'b1;
    k           = 0;
    saw_valid   = 1'b0;
    busy_first  = 1'b0;
    busy_last   = 1'b0;
    err_at_done = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start      = 1'b0;
        busy_first = busy;
      end
      if (mem_valid) saw_valid = 1'b1;
    end while (!done && k < limit);
    busy_last   = busy;
    err_at_done = error;
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  logic [31:0] exp_rand [511];
  int          nbad;
  bit          wv [13];
  bit          wd [13];
  bit          we [13];
  bit          wb [13];

  initial begin
    // reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    reset = 1'b0;

    // 4-word copy with a single-cycle-ack RAM
    for (int i = 0; i < 4; i++) begin
      mem[32'h40 + i] = 32'hA0 + i;
      mem[32'h80 + i] = 32'h0;
    end
    maxd = 0;
    run_copy(32'h100, 32'h200, 9'd4, 200);
    chk("c4_cycles", k, 32'd17);
    chk("c4_busy1",  {31'd0, busy_first}, 32'd1);
    chk("c4_error",  {31'd0, err_at_done}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("c4_dst", mem[32'h80 + i], 32'hA0 + i);
      chk("c4_src", mem[32'h40 + i], 32'hA0 + i);
    end
    @(negedge clk);
    chk("c4_done_pulse", {31'd0, done}, 32'd0);

    // empty copy: no bus traffic
    rd_log.delete();
    wr_log.delete();
    run_copy(32'h100, 32'h200, 9'd0, 50);
    chk("z_cycles", k, 32'd2);
    chk("z_valid",  {31'd0, saw_valid}, 32'd0);
    chk("z_busy1",  {31'd0, busy_first}, 32'd1);
    chk("z_busy2",  {31'd0, busy_last}, 32'd0);
    chk("z_error",  {31'd0, err_at_done}, 32'd0);
    chk("z_nacc",   rd_log.size() + wr_log.size(), 32'd0);

    // source wrap and unaligned destination
    mem[32'h3FFF_FFFF] = 32'h1111_0001;
    mem[32'h0]         = 32'h1111_0002;
    rd_log.delete();
    wr_log.delete();
    run_copy(32'hFFFF_FFFC, 32'h203, 9'd2, 100);
    chk("w_cycles", k, 32'd9);
    chk("w_nrd", rd_log.size(), 32'd2);
    chk("w_nwr", wr_log.size(), 32'd2);
    if (rd_log.size() == 2 && wr_log.size() == 2) begin
      chk("w_rd0", rd_log[0], 32'hFFFF_FFFC);
      chk("w_rd1", rd_log[1], 32'h0000_0000);
      chk("w_wr0", wr_log[0], 32'h0000_0200);
      chk("w_wr1", wr_log[1], 32'h0000_0204);
    end
    chk("w_m0", mem[32'h80], 32'h1111_0001);
    chk("w_m1", mem[32'h81], 32'h1111_0002);

    // watchdog abort on a write nobody answers
    @(negedge clk);
    src     = 32'h100;
    dst     = 32'h3000_0000;
    wc      = 9'd2;
    w_start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) w_start = 1'b0;
      wv[i] = w_valid;
      wd[i] = w_done;
      we[i] = w_error;
      wb[i] = w_busy;
    end
    chk("a_valid10", {31'd0, wv[10]}, 32'd1);
    chk("a_busy10",  {31'd0, wb[10]}, 32'd1);
    chk("a_done10",  {31'd0, wd[10]}, 32'd0);
    chk("a_valid11", {31'd0, wv[11]}, 32'd0);
    chk("a_done11",  {31'd0, wd[11]}, 32'd1);
    chk("a_error11", {31'd0, we[11]}, 32'd1);
    chk("a_busy11",  {31'd0, wb[11]}, 32'd0);
    chk("a_done12",  {31'd0, wd[12]}, 32'd0);
    chk("a_error12", {31'd0, we[12]}, 32'd0);

    // 511 words under random ack delays
    for (int i = 0; i < 511; i++) begin
      exp_rand[i] = $urandom;
      mem[32'h400 + i]  = exp_rand[i];
      mem[32'h1000 + i] = 32'h0;
    end
    maxd = 10;
    run_copy(32'h1000, 32'h4000, 9'd511, 30000);
    chk("r_error", {31'd0, err_at_done}, 32'd0);
    nbad = 0;
    for (int i = 0; i < 511; i++) begin
      if (mem[32'h1000 + i] !== exp_rand[i]) nbad++;
    end
    chk("r_mem", nbad, 32'd0);

    // reset during the third word, then a clean copy
    maxd  = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[32'h50 + i] = 32'hC000_0000 + i;
      mem[32'h90 + i] = 32'h0;
    end
    rd_log.delete();
    wr_log.delete();
    @(negedge clk);
    src   = 32'h140;
    dst   = 32'h240;
    wc    = 9'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (wr_log.size() < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("m_reach", {31'd0, k < 100}, 32'd1);
    @(negedge clk);
    chk("m_valid_pre", {31'd0, mem_valid}, 32'd1);
    chk("m_addr_pre",  mem_addr, 32'h148);
    reset = 1'b1;
    @(negedge clk);
    chk("m_valid_rst", {31'd0, mem_valid}, 32'd0);
    chk("m_busy_rst",  {31'd0, busy}, 32'd0);
    reset = 1'b0;
    chk("m_third", mem[32'h92], 32'h0);
    run_copy(32'h140, 32'h240, 9'd8, 200);
    chk("m_cycles", k, 32'd33);
    for (int i = 0; i < 8; i++) begin
      chk("m_dst", mem[32'h90 + i], 32'hC000_0000 + i);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
